instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Producer side of the decoder's instruction input. Holds the PC, issues word reads to instruction memory
//  over a valid/ready request + in-order response interface, buffers returned words, and presents
//  {instruction, pc} to decode with a valid/ready handshake. Execute-stage redirects (taken branch/JAL)
//  flush the buffer and discard stale in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              instruction buffer entries; also max outstanding + buffered words (>=1)
// PORTS
//  i_clk                    input   1   clock, all state on rising edge
//  i_reset                  input   1   asynchronous, active-high reset
//  o_imem_request_valid     output  1   read request valid
//  o_imem_address           output  32  word-aligned read address (current PC)
//  i_imem_request_ready     input   1   memory accepts request this cycle
//  i_imem_response_valid    input   1   read data valid; in order, >=1 cycle after acceptance
//  i_imem_response_data     input   32  instruction word (t_data)
//  o_instruction_valid      output  1   FIFO head valid toward decoder
//  o_instruction            output  32  FIFO head instruction word (t_data)
//  o_pc                     output  32  address of o_instruction
//  i_instruction_ready      input   1   decoder consumes head this cycle
//  i_redirect_valid         input   1   redirect PC (branch/jump taken)
//  i_redirect_target        input   32  new PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (async assert, sync use): pc=RESET_PC, state=FETCH, FIFO empty, outstanding=0, discard=0;
//   o_imem_request_valid=0, o_instruction_valid=0, o_instruction=0, o_pc=0, o_imem_address=RESET_PC.
//   Reset mid-transaction drops everything; responses to pre-reset requests must not occur (bench rule).
//  Credit: request issued only if state==FETCH and outstanding+fifo_count < FIFO_DEPTH; FIFO never overflows.
//  Request accepted (valid&&ready): outstanding+1, pc<=pc+4 (mod 2^32 wrap); the accepted address
//   is pushed to a pc-tag queue of depth FIFO_DEPTH; o_imem_address/valid combinational from pc/credit.
//  Response: if discard>0 -> drop word, discard-1, tag popped; else push {data,tag pc} into FIFO; outstanding-1.
//  Output: FIFO head drives o_instruction/o_pc; pop on valid&&ready. Push+pop same cycle legal when full.
//   Latency: response accepted at edge N -> o_instruction_valid high after edge N (empty FIFO).
//  States: FETCH (issuing allowed), DRAIN (no issue; waiting for discard==0 -> FETCH same edge it hits 0).
//  Redirect (highest priority): pc<=target&~3; FIFO flushed; o_instruction_valid=0 next cycle;
//   discard<=outstanding_next (includes request accepted and excludes response arriving that same cycle,
//   which is itself dropped); state<=DRAIN if discard_next>0 else FETCH. Request presented in the redirect
//   cycle still uses old pc; if accepted it is discarded. Decoder handshake in redirect cycle is honoured
//   for the head but flushed contents are never re-presented.
//  Response with outstanding==0 is illegal: assertion fires under simulation, word ignored.
//  Counter widths: $clog2(FIFO_DEPTH+1) bits for outstanding, discard, fifo_count.
// CONFIGURATION
//  FETCH_PERF_COUNTERS_EN defined: adds outputs o_fetch_count[31:0] (+1 per word delivered to decoder)
//   and o_flush_count[31:0] (+1 per redirect cycle), both reset 0, wrap at 2^32, no other effect.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  definitions package: add t_address (32-bit), t_fetch_entry struct {t_data instruction; t_address pc},
//   INSTRUCTION_BYTES=4 constant. Reuse t_data.
//  Sub-module fetch_fifo: parameterised sync FIFO of t_fetch_entry with push/pop/flush/count, flush
//   dominating push. pc-tag queue is a second fetch_fifo instance (instruction field unused).
// TESTING
//  Reset with RESET_PC=0x100, ready=1, 1-cycle memory -> addresses 0x100,0x104,0x108 in order; o_pc matches.
//  Decoder ready=0 with FIFO_DEPTH=2 -> exactly 2 requests issued then request_valid=0; ready=1 resumes.
//  Redirect to 0x203 with 2 outstanding -> next address 0x200, 2 responses dropped, first o_pc=0x200.
//  Redirect same cycle as response and request accept -> both stale words dropped, no stale o_pc ever seen.
//  PC 0xFFFF_FFFC fetch -> next address 0x0000_0000; i_reset asserted mid-fetch -> outputs 0 immediately.
//  FETCH_PERF_COUNTERS_EN: 5 words consumed, 2 redirects -> o_fetch_count=5, o_flush_count=2.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared types for the instruction fetch unit and its buffers.
//   t_data            32-bit instruction word
//   t_address         32-bit byte address
//   t_fetch_entry     {instruction, pc} pair held in the fetch buffers
//   t_fetch_state     FETCH (requests allowed) / DRAIN (waiting out stale responses)
//   INSTRUCTION_BYTES PC increment per fetched word
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int unsigned INSTRUCTION_BYTES = 4;

    typedef logic [31:0] t_data;
    typedef logic [31:0] t_address;

    typedef struct packed {
        t_data    instruction;
        t_address pc;
    } t_fetch_entry;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } t_fetch_state;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of t_fetch_entry with combinational head output.
// Flush dominates push; push while full is accepted only together with a pop.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_push          write i_push_entry at the tail
//   i_push_entry    entry to write
//   i_pop           drop the head entry (ignored when empty)
//   i_flush         empty the FIFO (wins over push and pop)
//   o_head          head entry (undefined content when empty)
//   o_count         number of valid entries
// ----------------------------------------------------------------------------
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  t_fetch_entry       i_push_entry,
    input  logic               i_pop,
    input  logic               i_flush,
    output t_fetch_entry       o_head,
    output logic [COUNT_W-1:0] o_count
);

    localparam int unsigned        PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    t_fetch_entry       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_COUNT) || w_do_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            r_count <= r_count + COUNT_W'(w_do_push) - COUNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: r_count qualifies every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Holds the PC, issues word reads to instruction memory (valid/ready request,
// in-order response), buffers returned words and presents {instruction, pc}
// to decode with a valid/ready handshake. Redirects flush the buffer and
// discard responses to requests already in flight.
// Optional feature: define FETCH_PERF_COUNTERS_EN to add o_fetch_count and
// o_flush_count.
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   o_imem_request_valid     read request valid
//   o_imem_address           word-aligned read address (current PC)
//   i_imem_request_ready     memory accepts request
//   i_imem_response_valid    read data valid (in order)
//   i_imem_response_data     instruction word
//   o_instruction_valid      buffer head valid toward decode
//   o_instruction, o_pc      buffer head word and its address
//   i_instruction_ready      decode consumes head
//   i_redirect_valid         redirect PC
//   i_redirect_target        new PC, bits [1:0] forced to 0
//   o_fetch_count            words delivered to decode (option)
//   o_flush_count            redirect cycles (option)
// ----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_request_valid,
    output logic [31:0] o_imem_address,
    input  logic        i_imem_request_ready,
    input  logic        i_imem_response_valid,
    input  logic [31:0] i_imem_response_data,
    output logic        o_instruction_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    input  logic        i_instruction_ready,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_flush_count,
`endif
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target
);

    localparam int unsigned      COUNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [COUNT_W:0] CREDIT_LIMIT = (COUNT_W + 1)'(FIFO_DEPTH);

    t_fetch_state       r_state;
    t_fetch_state       w_state_next;
    t_address           r_pc;
    logic [COUNT_W-1:0] r_discard;
    logic [COUNT_W-1:0] w_discard_next;
    logic [COUNT_W-1:0] w_outstanding;
    logic [COUNT_W-1:0] w_outstanding_next;
    logic [COUNT_W-1:0] w_fifo_count;
    logic               w_credit;
    logic               w_request_fire;
    logic               w_response_accept;
    logic               w_push_instr;
    logic               w_pop_instr;
    logic               w_instr_valid;
    t_fetch_entry       w_tag_push;
    t_fetch_entry       w_tag_head;
    t_fetch_entry       w_instr_push;
    t_fetch_entry       w_instr_head;
    logic               w_unused_tag_instruction;

    // Words in flight plus words buffered never exceed the buffer size.
    assign w_credit = ({1'b0, w_outstanding} + {1'b0, w_fifo_count}) < CREDIT_LIMIT;

    assign w_request_fire     = o_imem_request_valid && i_imem_request_ready;
    assign w_response_accept  = i_imem_response_valid && (w_outstanding != '0);
    // A response landing in the redirect cycle is stale and dropped.
    assign w_push_instr       = w_response_accept && (r_discard == '0) && !i_redirect_valid;
    assign w_instr_valid      = (w_fifo_count != '0);
    assign w_pop_instr        = w_instr_valid && i_instruction_ready;
    assign w_outstanding_next = w_outstanding + COUNT_W'(w_request_fire)
                              - COUNT_W'(w_response_accept);

    assign w_tag_push   = '{instruction: '0, pc: r_pc};
    assign w_instr_push = '{instruction: i_imem_response_data, pc: w_tag_head.pc};
    assign w_unused_tag_instruction = ^w_tag_head.instruction;

    // The pc-tag queue occupancy is the outstanding-request count. It is never
    // flushed: stale responses still pop their tags as they are discarded.
    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .COUNT_W (COUNT_W)
    ) u_tag_queue (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (w_request_fire),
        .i_push_entry (w_tag_push),
        .i_pop        (w_response_accept),
        .i_flush      (1'b0),
        .o_head       (w_tag_head),
        .o_count      (w_outstanding)
    );

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .COUNT_W (COUNT_W)
    ) u_instr_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (w_push_instr),
        .i_push_entry (w_instr_push),
        .i_pop        (w_pop_instr),
        .i_flush      (i_redirect_valid),
        .o_head       (w_instr_head),
        .o_count      (w_fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_discard_next = r_discard;
        if (i_redirect_valid) begin
            w_discard_next = w_outstanding_next;
            w_state_next   = (w_outstanding_next != '0) ? DRAIN : FETCH;
        end else begin
            if (w_response_accept && (r_discard != '0)) begin
                w_discard_next = r_discard - 1'b1;
            end
            if ((r_state == DRAIN) && (w_discard_next == '0)) begin
                w_state_next = FETCH;
            end
        end
    end

    always_comb begin
        o_imem_request_valid = !i_reset && (r_state == FETCH) && w_credit;
        o_imem_address       = r_pc;
        o_instruction_valid  = w_instr_valid;
        o_instruction        = w_instr_valid ? w_instr_head.instruction : '0;
        o_pc                 = w_instr_valid ? w_instr_head.pc : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else begin
            r_discard <= w_discard_next;
            if (i_redirect_valid) begin
                r_pc <= i_redirect_target & ~32'h3;
            end else if (w_request_fire) begin
                r_pc <= r_pc + 32'(INSTRUCTION_BYTES);
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_pop_instr) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (i_redirect_valid) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign o_fetch_count = r_fetch_count;
    assign o_flush_count = r_flush_count;
`endif

    a_response_has_request: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_imem_response_valid && (w_outstanding == '0)));

endmodule
